// File: rtl/arb8_rr.sv
// arb8_rr: round-robin arbiter sharing one datapath port among eight requesters,
// with completion-driven release, request-drop release and a bounded hold time.
module arb8_rr #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic {IDLE, OWN} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
  state_t           r_state, w_state;
  logic [2:0]       r_ptr, w_ptr, r_sel, w_sel, w_base, w_idx, w_win;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [7:0]       r_grant, w_grant, w_mask;
  logic             r_busy, w_busy, r_timeout, w_timeout;
  logic             w_own, w_found, w_rel_a, w_rel_b, w_rel_c, w_rel;
  assign w_own   = r_state == OWN;
  assign w_rel_a = done;
  assign w_rel_b = ~req[r_sel];
  assign w_rel_c = (MAX_HOLD != 0) && (r_cnt == LAST);
  assign w_rel   = w_rel_a | w_rel_b | w_rel_c;
  // While owning, the search starts past the owner and excludes it.
  assign w_base  = w_own ? r_sel + 3'd1 : r_ptr;
  assign w_mask  = w_own ? req & ~(8'd1 << r_sel) : req;
  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    w_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      w_idx = w_base + 3'(i);
      if (w_mask[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end
  always_comb begin
    w_state   = r_state;
    w_ptr     = r_ptr;
    w_cnt     = r_cnt;
    w_grant   = r_grant;
    w_sel     = r_sel;
    w_busy    = r_busy;
    w_timeout = 1'b0;
    if (!w_own) begin
      if (w_found) begin
        w_state = OWN;
        w_grant = 8'd1 << w_win;
        w_sel   = w_win;
        w_busy  = 1'b1;
        w_cnt   = '0;
      end
    end else if (w_rel) begin
      w_ptr     = r_sel + 3'd1;
      w_cnt     = '0;
      w_timeout = w_rel_c & ~w_rel_a & ~w_rel_b;
      if (w_found) begin
        w_grant = 8'd1 << w_win;
        w_sel   = w_win;
      end else begin
        w_state = IDLE;
        w_grant = 8'd0;
        w_busy  = 1'b0;
      end
    end else begin
      w_cnt = (MAX_HOLD == 0 || r_cnt == LAST) ? r_cnt : r_cnt + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= 3'd0;
      r_cnt     <= '0;
      r_grant   <= 8'd0;
      r_sel     <= 3'd0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_ptr     <= w_ptr;
      r_cnt     <= w_cnt;
      r_grant   <= w_grant;
      r_sel     <= w_sel;
      r_busy    <= w_busy;
      r_timeout <= w_timeout;
    end
  end
  assign grant   = r_grant;
  assign sel     = r_sel;
  assign busy    = r_busy;
  assign timeout = r_timeout;
endmodule
